// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap/CSR unit: CSR addresses, cause codes,
// mstatus bit positions and the per-cycle trap event type.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_ILL      = 32'd2;
    localparam logic [31:0] CAUSE_ECALL    = 32'd11;
    localparam logic [4:0]  CAUSE_IRQ_BASE = 5'd16;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_ILL,
        EV_ECALL,
        EV_MRET,
        EV_IRQ
    } trap_ev_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source interrupt input stage: multi-flop synchroniser, and for edge sources a
// sticky pending bit set by a rising edge and cleared by acknowledge or W1C.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    output logic mip
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pending_q;
    logic                   rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
        end
    end

    // Edge is taken one stage early so pending lands on the same edge the synced
    // level would, keeping edge and level sources at equal latency.
    assign rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= 1'b0;
        end else if (rise) begin
            pending_q <= 1'b1;
        end else if (clr) begin
            pending_q <= 1'b0;
        end
    end

    assign mip = EDGE ? pending_q : sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_unit_multi.sv
// Machine-mode trap and CSR unit: prioritised exceptions, mret and N_IRQ external
// interrupts with direct or vectored entry, driving the datapath PC redirect.
module trap_unit_multi
    import trap_pkg::*;
#(
    parameter int unsigned      N_IRQ       = 4,
    parameter logic [N_IRQ-1:0] EDGE_MASK   = N_IRQ'(4'b0011),
    parameter logic [31:0]      MTVEC_RST   = 32'h0000_0100,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic             instr_valid,
    input  logic [31:0]      pc_cur,
    input  logic [31:0]      pc_next,
    input  logic             ill_instr,
    input  logic             ecall,
    input  logic             mret,
    input  logic [11:0]      csr_addr,
    input  logic             csr_we,
    input  logic [31:0]      csr_wdata,
    output logic [31:0]      csr_rdata,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [N_IRQ-1:0] irq_ack,
    output logic [31:0]      mepc_o,
    output logic [31:0]      mcause_o,
    output logic             in_trap
);

    logic             st_mie_q;
    logic             st_mpie_q;
    logic [N_IRQ-1:0] mie_q;
    logic [31:0]      mtvec_q;
    logic [31:2]      mepc_q;
    logic [31:0]      mcause_q;

    logic [N_IRQ-1:0] mip;
    logic [N_IRQ-1:0] irq_act;
    logic [N_IRQ-1:0] irq_clr;
    logic [N_IRQ-1:0] ack;
    logic             irq_hit;
    logic [3:0]       irq_idx;
    logic [4:0]       irq_code;
    logic [31:0]      tvec_base;
    logic             csr_wr;
    trap_ev_e         ev;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^{pc_cur[1:0], pc_next[1:0]};

    for (genvar g = 0; g < N_IRQ; g++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES),
            .EDGE       (EDGE_MASK[g])
        ) u_sync (
            .clk(clk),
            .rst(rst),
            .irq(irq[g]),
            .clr(irq_clr[g]),
            .mip(mip[g])
        );
    end

    assign csr_wr  = csr_we & instr_valid;
    assign irq_clr = ack | ((csr_wr && csr_addr == CSR_MIP) ? csr_wdata[N_IRQ+15:16] : '0);

    // Event selection: lowest enabled pending source, then fixed event priority.
    always_comb begin
        irq_act = mip & mie_q;
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (irq_act[i] && !irq_hit) begin
                irq_hit = 1'b1;
                irq_idx = 4'(i);
            end
        end

        ev = EV_NONE;
        if (instr_valid) begin
            if (ill_instr)                 ev = EV_ILL;
            else if (ecall)                ev = EV_ECALL;
            else if (mret)                 ev = EV_MRET;
            else if (st_mie_q && irq_hit)  ev = EV_IRQ;
        end
    end

    assign irq_code  = CAUSE_IRQ_BASE + {1'b0, irq_idx};
    assign tvec_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        redirect    = (ev != EV_NONE);
        redirect_pc = '0;
        ack         = '0;
        case (ev)
            EV_ILL, EV_ECALL: redirect_pc = tvec_base;
            EV_MRET:          redirect_pc = {mepc_q, 2'b00};
            EV_IRQ: begin
                redirect_pc = mtvec_q[0] ? tvec_base + {25'b0, irq_code, 2'b00} : tvec_base;
                ack         = N_IRQ'(1) << irq_idx;
            end
            default: ;
        endcase
    end

    assign irq_ack  = ack;
    assign mepc_o   = {mepc_q, 2'b00};
    assign mcause_o = mcause_q;
    assign in_trap  = ~st_mie_q;

    // Trap and mret updates take precedence over a same-cycle CSR write to the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_mie_q  <= 1'b0;
            st_mpie_q <= 1'b0;
            mie_q     <= '0;
            mtvec_q   <= MTVEC_RST;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            case (ev)
                EV_ILL, EV_ECALL, EV_IRQ: begin
                    st_mpie_q <= st_mie_q;
                    st_mie_q  <= 1'b0;
                end
                EV_MRET: begin
                    st_mie_q  <= st_mpie_q;
                    st_mpie_q <= 1'b1;
                end
                default: begin
                    if (csr_wr && csr_addr == CSR_MSTATUS) begin
                        st_mie_q  <= csr_wdata[MSTATUS_MIE];
                        st_mpie_q <= csr_wdata[MSTATUS_MPIE];
                    end
                end
            endcase

            case (ev)
                EV_ILL: begin
                    mepc_q   <= pc_cur[31:2];
                    mcause_q <= CAUSE_ILL;
                end
                EV_ECALL: begin
                    mepc_q   <= pc_cur[31:2];
                    mcause_q <= CAUSE_ECALL;
                end
                EV_IRQ: begin
                    mepc_q   <= pc_next[31:2];
                    mcause_q <= {1'b1, 26'b0, irq_code};
                end
                default: begin
                    if (csr_wr && csr_addr == CSR_MEPC)   mepc_q   <= csr_wdata[31:2];
                    if (csr_wr && csr_addr == CSR_MCAUSE) mcause_q <= csr_wdata;
                end
            endcase

            if (csr_wr && csr_addr == CSR_MIE)   mie_q   <= csr_wdata[N_IRQ+15:16];
            if (csr_wr && csr_addr == CSR_MTVEC) mtvec_q <= {csr_wdata[31:2], 1'b0, csr_wdata[0]};
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE]  = st_mie_q;
                csr_rdata[MSTATUS_MPIE] = st_mpie_q;
            end
            CSR_MIE:    csr_rdata[N_IRQ+15:16] = mie_q;
            CSR_MTVEC:  csr_rdata = mtvec_q;
            CSR_MEPC:   csr_rdata = {mepc_q, 2'b00};
            CSR_MCAUSE: csr_rdata = mcause_q;
            CSR_MIP:    csr_rdata[N_IRQ+15:16] = mip;
            default:    csr_rdata = '0;
        endcase
    end

endmodule
